// File: rtl/seg7_pkg.sv
// Shared constants, converter state type and sizing helpers for the 7-segment display controller.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

  // Decimal digits needed for a data_w-bit unsigned value (log10(2) ~= 0.302).
  function automatic int bcd_digits(input int data_w);
    return (data_w * 302) / 1000 + 1;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = SEG_0;
      4'd1:    p = SEG_1;
      4'd2:    p = SEG_2;
      4'd3:    p = SEG_3;
      4'd4:    p = SEG_4;
      4'd5:    p = SEG_5;
      4'd6:    p = SEG_6;
      4'd7:    p = SEG_7;
      4'd8:    p = SEG_8;
      4'd9:    p = SEG_9;
      default: p = SEG_E;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, DATA_W steps,
// then a single COMMIT cycle during which done is high and bcd holds the result.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BCD_N  = bcd_digits(DATA_W)
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DATA_W-1:0]    bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [4*BCD_N-1:0]   bcd
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  conv_state_e          state_q, state_d;
  logic [DATA_W-1:0]    bin_q, bin_d;
  logic [4*BCD_N-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_N; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          bin_d   = bin_in;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == COMMIT);
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Binary-to-decimal 7-segment controller: sign/blanking/overflow formatting of the converter
// result, a static per-digit segment bus and a time-multiplexed seg/an scan.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_DIGITS  = 3,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk50,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       value_in,
  input  logic                    load,
  input  logic                    signed_en,
  input  logic                    blank_lz,
  output logic                    busy,
  output logic                    ovf,
  output logic [7*NUM_DIGITS-1:0] seg_all,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int BCD_N = bcd_digits(DATA_W);
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{ACTIVE_LOW}};

  logic                 conv_busy, conv_done, start;
  logic [4*BCD_N-1:0]   bcd;
  logic [DATA_W-1:0]    mag;
  logic                 neg_in;

  logic                 neg_q, neg_d;
  logic                 blank_q, blank_d;
  logic                 ovf_q, ovf_d;
  logic [6:0]           digit_q [NUM_DIGITS];
  logic [6:0]           digit_d [NUM_DIGITS];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     scan_q, scan_d;
  logic [6:0]           seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic [3:0]           bcd_dig [NUM_DIGITS];
  logic [6:0]           fmt [NUM_DIGITS];
  logic                 fmt_ovf;
  logic [6:0]           cur_pat;

  assign start  = load && !conv_busy;
  assign neg_in = signed_en && value_in[DATA_W-1];
  assign mag    = neg_in ? (~value_in + 1'b1) : value_in;

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_N(BCD_N)) u_bin2bcd (
    .clk50  (clk50),
    .reset  (reset),
    .start  (start),
    .bin_in (mag),
    .busy   (conv_busy),
    .done   (conv_done),
    .bcd    (bcd)
  );

  // Display positions beyond the converter width always read as zero.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
    if (gi < BCD_N) begin : g_have
      assign bcd_dig[gi] = bcd[4*gi +: 4];
    end else begin : g_zero
      assign bcd_dig[gi] = 4'd0;
    end
    assign seg_all[7*gi +: 7] = ACTIVE_LOW ? ~digit_q[gi] : digit_q[gi];
  end

  always_comb begin
    int avail;
    int msd;
    int minus_pos;
    avail   = neg_q ? NUM_DIGITS - 1 : NUM_DIGITS;
    fmt_ovf = 1'b0;
    for (int i = 0; i < BCD_N; i++) begin
      if (i >= avail && bcd[4*i +: 4] != 4'd0) fmt_ovf = 1'b1;
    end
    msd = 0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_dig[k] != 4'd0) msd = k;
    end
    minus_pos = blank_q ? msd + 1 : NUM_DIGITS - 1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (fmt_ovf)                  fmt[k] = SEG_E;
      else if (neg_q && k == minus_pos) fmt[k] = SEG_MINUS;
      else if (blank_q && k > msd)  fmt[k] = SEG_BLANK;
      else                          fmt[k] = seg_of(bcd_dig[k]);
    end
  end

  always_comb begin
    neg_d   = start ? neg_in   : neg_q;
    blank_d = start ? blank_lz : blank_q;
    ovf_d   = conv_done ? fmt_ovf : ovf_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digit_d[k] = conv_done ? fmt[k] : digit_q[k];
    end
    cur_pat = SEG_BLANK;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (scan_q == IDX_W'(k)) cur_pat = digit_q[k];
    end
    cnt_d  = cnt_q + 1'b1;
    scan_d = scan_q;
    seg_d  = seg_q;
    an_d   = an_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      scan_d = (scan_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_q + 1'b1;
      seg_d  = ACTIVE_LOW ? ~cur_pat : cur_pat;
      an_d   = ACTIVE_LOW ? ~(NUM_DIGITS'(1) << scan_q) : (NUM_DIGITS'(1) << scan_q);
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      neg_q   <= 1'b0;
      blank_q <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= SEG_BLANK;
      cnt_q   <= '0;
      scan_q  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
    end else begin
      neg_q   <= neg_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < NUM_DIGITS; k++) digit_q[k] <= digit_d[k];
      cnt_q   <= cnt_d;
      scan_q  <= scan_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign busy = conv_busy;
  assign ovf  = ovf_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl (DATA_W=8, NUM_DIGITS=3, REFRESH_DIV=4, active-low pins).
module tb_seg7_display_ctrl;

  logic        clk50 = 1'b0;
  logic        reset;
  logic [7:0]  value_in;
  logic        load, signed_en, blank_lz;
  logic        busy, ovf;
  logic [20:0] seg_all;
  logic [6:0]  seg;
  logic [2:0]  an;

  int checks = 0;
  int errors = 0;

  seg7_display_ctrl #(
    .DATA_W(8), .NUM_DIGITS(3), .REFRESH_DIV(4), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk50     (clk50),
    .reset     (reset),
    .value_in  (value_in),
    .load      (load),
    .signed_en (signed_en),
    .blank_lz  (blank_lz),
    .busy      (busy),
    .ovf       (ovf),
    .seg_all   (seg_all),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    logic [7:0] value;
    logic       sgn;
    logic       blz;
    logic [6:0] d2, d1, d0;   // expected pin-level (active-low) patterns
    logic       ovf;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after busy falls, with busy cycle count.
  task automatic do_load(input logic [7:0] v, input logic s, input logic b, output int cyc);
    value_in = v; signed_en = s; blank_lz = b; load = 1'b1;
    @(negedge clk50);
    load = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk50);
    end
  endtask

  initial begin
    int cyc;
    int ok;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;
    logic [6:0] pat255 [3];

    vecs[0]  = '{8'd255, 1'b0, 1'b0, 7'h24, 7'h12, 7'h12, 1'b0};
    vecs[1]  = '{8'hFB,  1'b1, 1'b1, 7'h7F, 7'h3F, 7'h12, 1'b0};
    vecs[2]  = '{8'hFB,  1'b1, 1'b0, 7'h3F, 7'h40, 7'h12, 1'b0};
    vecs[3]  = '{8'h80,  1'b1, 1'b0, 7'h06, 7'h06, 7'h06, 1'b1};
    vecs[4]  = '{8'd7,   1'b0, 1'b1, 7'h7F, 7'h7F, 7'h78, 1'b0};
    vecs[5]  = '{8'd0,   1'b0, 1'b1, 7'h7F, 7'h7F, 7'h40, 1'b0};
    vecs[6]  = '{8'd0,   1'b1, 1'b0, 7'h40, 7'h40, 7'h40, 1'b0};
    vecs[7]  = '{8'd100, 1'b0, 1'b1, 7'h79, 7'h40, 7'h40, 1'b0};
    vecs[8]  = '{8'h9D,  1'b1, 1'b1, 7'h3F, 7'h10, 7'h10, 1'b0};
    vecs[9]  = '{8'h9C,  1'b1, 1'b1, 7'h06, 7'h06, 7'h06, 1'b1};
    vecs[10] = '{8'hC8,  1'b0, 1'b0, 7'h24, 7'h40, 7'h40, 1'b0};
    vecs[11] = '{8'h7F,  1'b1, 1'b0, 7'h79, 7'h24, 7'h78, 1'b0};
    vecs[12] = '{8'hFF,  1'b1, 1'b1, 7'h7F, 7'h3F, 7'h79, 1'b0};
    pat255[0] = 7'h12; pat255[1] = 7'h12; pat255[2] = 7'h24;

    value_in = '0; load = 1'b0; signed_en = 1'b0; blank_lz = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk50);
    check("rst_seg", seg, 7'h7F);
    check("rst_an", an, 3'b111);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_seg_all", seg_all, 21'h1FFFFF);
    reset = 1'b1;
    repeat (10) @(negedge clk50);
    check("idle_seg_all", seg_all, 21'h1FFFFF);
    check("idle_seg", seg, 7'h7F);
    check("idle_busy", busy, 1'b0);
    check("idle_ovf", ovf, 1'b0);
    $display("reset: seg=%h an=%b seg_all=%h", seg, an, seg_all);

    foreach (vecs[i]) begin
      do_load(vecs[i].value, vecs[i].sgn, vecs[i].blz, cyc);
      check($sformatf("v%0d_busy_cycles", i), cyc, 9);
      check($sformatf("v%0d_seg_all", i), seg_all, {vecs[i].d2, vecs[i].d1, vecs[i].d0});
      check($sformatf("v%0d_ovf", i), ovf, vecs[i].ovf);
      $display("vec %0d: value=%h signed=%b blank=%b busy=%0d seg_all=%h ovf=%b",
               i, vecs[i].value, vecs[i].sgn, vecs[i].blz, cyc, seg_all, ovf);
    end

    // Scan: digit 0 enabled first, each digit held REFRESH_DIV cycles.
    do_load(8'd255, 1'b0, 1'b0, cyc);
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (an != 3'b110) ok = 1; else @(negedge clk50);
    end
    ok = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      if (an == 3'b110) ok = 1; else @(negedge clk50);
    end
    check("scan_align", ok, 1);
    for (int s = 0; s < 4; s++) begin
      exp_an  = ~(3'b001 << (s % 3));
      exp_seg = pat255[s % 3];
      for (int c = 0; c < 4; c++) begin
        check($sformatf("scan_an_s%0d_c%0d", s, c), an, exp_an);
        check($sformatf("scan_seg_s%0d_c%0d", s, c), seg, exp_seg);
        @(negedge clk50);
      end
      $display("scan step %0d: an=%b seg=%h", s, exp_an, exp_seg);
    end

    // load during busy is dropped.
    value_in = 8'd7; signed_en = 1'b0; blank_lz = 1'b0; load = 1'b1;
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk50);
      if (busy) cyc++;
      if (i == 0) load = 1'b0;
      if (i == 2) begin value_in = 8'd255; load = 1'b1; end
      if (i == 5) load = 1'b0;
    end
    check("busyload_cycles", cyc, 9);
    check("busyload_seg_all", seg_all, {7'h40, 7'h40, 7'h78});
    check("busyload_idle", busy, 1'b0);
    $display("load-while-busy: busy=%0d seg_all=%h", cyc, seg_all);

    // Reset during SHIFT aborts without committing.
    value_in = 8'd255; signed_en = 1'b0; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk50);
    load = 1'b0;
    repeat (3) @(negedge clk50);
    check("pre_abort_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_seg_all", seg_all, 21'h1FFFFF);
    check("abort_seg", seg, 7'h7F);
    check("abort_an", an, 3'b111);
    check("abort_ovf", ovf, 1'b0);
    @(negedge clk50);
    reset = 1'b1;
    @(negedge clk50);
    do_load(8'h9D, 1'b1, 1'b1, cyc);
    check("post_abort_cycles", cyc, 9);
    check("post_abort_seg_all", seg_all, {7'h3F, 7'h10, 7'h10});
    $display("after abort: busy=%0d seg_all=%h", cyc, seg_all);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
